// File: rtl/addsub_serial4.sv
// Nibble-serial add/subtract: one 4-bit propagate/generate slice per cycle, carry held between nibbles.
// Optional signed saturation of the result is enabled by defining ADDSUB_SERIAL4_SAT_EN.
module addsub_serial4 #(
  parameter int WIDTH = 32,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             sat_q, sat_d;

  logic [3:0] nib_a, nib_b, g, p, c, sum;
  logic       gg, pg, co;

  // Carry-lookahead slice; c[3] is the carry into the nibble MSB, needed for overflow.
  always_comb begin
    nib_a = a_q[{cnt_q, 2'b00} +: 4];
    nib_b = b_q[{cnt_q, 2'b00} +: 4];
    g     = nib_a & nib_b;
    p     = nib_a ^ nib_b;
    c[0]  = c_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & c[1]);
    c[3]  = g[2] | (p[2] & c[2]);
    gg    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg    = &p;
    co    = gg | (pg & c_q);
    sum   = p ^ c;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = cin ^ sub;
          cnt_d   = '0;
          sat_d   = sat;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[{cnt_q, 2'b00} +: 4] = sum;
        c_d = co;
        if (cnt_q == CW'(NIB - 1)) begin
          cout_d = co;
          ovf_d  = c[3] ^ co;
`ifdef ADDSUB_SERIAL4_SAT_EN
          if (sat_q && (c[3] ^ co)) begin
            s_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
          zero_d  = (s_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef ADDSUB_SERIAL4_SAT_EN
  logic sat_q_unused;
  assign sat_q_unused = sat_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      sat_q   <= sat_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_addsub_serial4.sv
// Directed self-checking bench for addsub_serial4 (WIDTH=32); saturation expectations follow ADDSUB_SERIAL4_SAT_EN.
module tb_addsub_serial4;

  logic        clk = 1'b0;
  logic        rst_n, start, sub, cin, sat;
  logic [31:0] a, b;
  logic        busy, done, cout, ovf, zero;
  logic [31:0] s;

  int checks = 0;
  int failures = 0;

  addsub_serial4 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .sat(sat),
    .a(a), .b(b), .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after done has dropped.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic icin, input logic isat);
    int lat;
    a = ia; b = ib; sub = isub; cin = icin; sat = isat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; sub = ~isub; cin = ~icin; sat = ~isat;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  task automatic expect_res(input string tag, input logic [31:0] es, input logic ec,
                            input logic eo, input logic ez);
    check({tag, "_s"}, s, es);
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
  endtask

  initial begin
    int dcount;
    int wide;
    int wait_cyc;
    logic prev_done;
    logic [31:0] sat_pos, sat_neg;

`ifdef ADDSUB_SERIAL4_SAT_EN
    sat_pos = 32'h7FFF_FFFF;
    sat_neg = 32'h8000_0000;
`else
    sat_pos = 32'h8000_0000;
    sat_neg = 32'h7FFF_FFFF;
`endif

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; sat = 1'b0;
    a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    expect_res("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of RUN
    a = 32'h1234_5678; b = 32'h1; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_s", s, 32'h0);
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 32'd0);

    run_op("add", 32'h0000_000F, 32'h1, 1'b0, 1'b0, 1'b0);
    expect_res("add", 32'h0000_0010, 1'b0, 1'b0, 1'b0);

    run_op("sub_borrow", 32'h0, 32'h1, 1'b1, 1'b0, 1'b0);
    expect_res("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    run_op("sub_eq", 32'h5, 32'h5, 1'b1, 1'b0, 1'b0);
    expect_res("sub_eq", 32'h0, 1'b1, 1'b0, 1'b1);

    // Outputs must hold through IDLE
    repeat (3) @(negedge clk);
    expect_res("hold", 32'h0, 1'b1, 1'b0, 1'b1);

    run_op("ovf_wrap", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    expect_res("ovf_wrap", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    run_op("ovf_satp", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
    expect_res("ovf_satp", sat_pos, 1'b0, 1'b1, 1'b0);

    run_op("ovf_satn", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b1);
    expect_res("ovf_satn", sat_neg, 1'b1, 1'b1, 1'b0);

    run_op("chain", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_res("chain", 32'h0, 1'b1, 1'b0, 1'b1);

    run_op("add_cin", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
    expect_res("add_cin", 32'h2345_678A, 1'b0, 1'b0, 1'b0);

    run_op("sub_bin", 32'd10, 32'd3, 1'b1, 1'b1, 1'b0);
    expect_res("sub_bin", 32'd6, 1'b1, 1'b0, 1'b0);

    // start held for 20 cycles: accepts in IDLE and at first DONE, two done pulses in the window
    a = 32'h1; b = 32'h2; sub = 1'b0; cin = 1'b0; sat = 1'b0; start = 1'b1;
    dcount = 0; wide = 0; prev_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) begin a = 32'h10; b = 32'h20; end
      if (i == 3) check("hs_busy", {31'd0, busy}, 32'd1);
      if (i == 8) begin
        check("hs_done1", {31'd0, done}, 32'd1);
        check("hs_s1", s, 32'h3);
      end
      if (i == 17) begin
        check("hs_done2", {31'd0, done}, 32'd1);
        check("hs_s2", s, 32'h30);
      end
      if (done) dcount++;
      if (done && prev_done) wide++;
      prev_done = done;
    end
    start = 1'b0;
    check("hs_count", dcount, 32'd2);
    check("hs_wide", wide, 32'd0);
    wait_cyc = 0;
    while (!done && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("hs_done3", {31'd0, done}, 32'd1);
    check("hs_s3", s, 32'h30);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
